// File: rtl/dap_resp_tx_if.sv
// Response RAM read port and outbound DAP byte stream of dap_resp_tx.
// The master side is the transmitter. The slave side is the RAM and stream sink.
interface dap_resp_tx_if #(
  parameter int ADDRWIDTH = 10
);
  logic [ADDRWIDTH-1:0] ram_read_addr;
  logic                 ram_read_en;
  logic [7:0]           ram_read_data;
  logic                 dap_out_tvalid;
  logic                 dap_out_tready;
  logic [7:0]           dap_out_tdata;
  logic                 dap_out_tlast;

  modport master (
    output ram_read_addr, ram_read_en,
    input  ram_read_data,
    output dap_out_tvalid, dap_out_tdata, dap_out_tlast,
    input  dap_out_tready
  );

  modport slave (
    input  ram_read_addr, ram_read_en,
    output ram_read_data,
    input  dap_out_tvalid, dap_out_tdata, dap_out_tlast,
    output dap_out_tready
  );
endinterface

// File: rtl/dap_resp_tx.sv
// Streams packet_len bytes from the response RAM (one-cycle read latency) onto an
// AXI-stream byte port, using a 2-entry output/skid buffer and a bypass for fresh RAM data.
module dap_resp_tx #(
  parameter int ADDRWIDTH = 10
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [ADDRWIDTH-1:0] packet_len,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  dap_resp_tx_if.master        bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEND  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [ADDRWIDTH-1:0] ONE = {{(ADDRWIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           state_q, state_d;
  logic [ADDRWIDTH-1:0] len_q, len_d;
  logic [ADDRWIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDRWIDTH-1:0] snd_cnt_q, snd_cnt_d;
  logic                 rd_vld_q, rd_vld_d;
  logic                 out_v_q, out_v_d;
  logic [7:0]           out_data_q, out_data_d;
  logic                 skid_v_q, skid_v_d;
  logic [7:0]           skid_data_q, skid_data_d;
  logic                 done_q, done_d;

  logic [1:0]           occ_sum;
  logic                 rd_issue;
  logic                 tvalid;
  logic                 tlast;
  logic                 hs;
  logic [ADDRWIDTH-1:0] last_idx;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    len_d       = len_q;
    rd_cnt_d    = rd_cnt_q;
    snd_cnt_d   = snd_cnt_q;
    out_v_d     = out_v_q;
    out_data_d  = out_data_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    done_d      = 1'b0;

    last_idx = len_q - ONE;
    // Buffered bytes plus the read whose data is arriving now never exceed two.
    occ_sum  = {1'b0, out_v_q} + {1'b0, skid_v_q} + {1'b0, rd_vld_q};
    rd_issue = (state_q == S_SEND) && (occ_sum < 2'd2);
    rd_vld_d = rd_issue;

    // Fresh RAM data is presented directly when the output register is empty.
    tvalid = out_v_q | rd_vld_q;
    tlast  = tvalid && (snd_cnt_q == last_idx);
    hs     = tvalid && bus.dap_out_tready;

    bus.ram_read_en    = rd_issue;
    bus.ram_read_addr  = rd_cnt_q;
    bus.dap_out_tvalid = tvalid;
    bus.dap_out_tlast  = tlast;
    bus.dap_out_tdata  = out_v_q ? out_data_q : (rd_vld_q ? bus.ram_read_data : 8'h00);

    if (!out_v_q) begin
      out_v_d = rd_vld_q && !hs;
      if (rd_vld_q) out_data_d = bus.ram_read_data;
    end else if (!skid_v_q) begin
      if (hs) begin
        out_v_d = rd_vld_q;
        if (rd_vld_q) out_data_d = bus.ram_read_data;
      end else begin
        skid_v_d = rd_vld_q;
        if (rd_vld_q) skid_data_d = bus.ram_read_data;
      end
    end else if (hs) begin
      out_data_d = skid_data_q;
      skid_v_d   = 1'b0;
    end

    rd_cnt_d  = rd_cnt_q + {{(ADDRWIDTH-1){1'b0}}, rd_issue};
    snd_cnt_d = snd_cnt_q + {{(ADDRWIDTH-1){1'b0}}, hs};

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (packet_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = S_SEND;
            len_d     = packet_len;
            rd_cnt_d  = '0;
            snd_cnt_d = '0;
          end
        end
      end
      S_SEND: begin
        if (rd_issue && (rd_cnt_q == last_idx)) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (hs && tlast) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          rd_cnt_d  = '0;
          snd_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort drops everything, including a read still in flight, and suppresses done.
    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      out_v_d   = 1'b0;
      skid_v_d  = 1'b0;
      rd_vld_d  = 1'b0;
      rd_cnt_d  = '0;
      snd_cnt_d = '0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      rd_cnt_q    <= '0;
      snd_cnt_q   <= '0;
      rd_vld_q    <= 1'b0;
      out_v_q     <= 1'b0;
      skid_v_q    <= 1'b0;
      // NOTE: the data registers are reset as well, so tdata reads zero while in reset.
      out_data_q  <= 8'h00;
      skid_data_q <= 8'h00;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking updates make every flop sample pre-edge values, independent of order.
      state_q     <= state_d;
      len_q       <= len_d;
      rd_cnt_q    <= rd_cnt_d;
      snd_cnt_q   <= snd_cnt_d;
      rd_vld_q    <= rd_vld_d;
      out_v_q     <= out_v_d;
      skid_v_q    <= skid_v_d;
      out_data_q  <= out_data_d;
      skid_data_q <= skid_data_d;
      done_q      <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule

// File: doc/dap_resp_tx.md
DAP_RESP_TX -- requirements
Module: dap_resp_tx

Interface
REQ-001 SHALL have parameter: ADDRWIDTH, default 10, response RAM address and length width.
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  one-cycle pulse, begin sending one response packet.
REQ-005 SHALL have port: packet_len  input  ADDRWIDTH  byte count, sampled on the start cycle.
REQ-006 SHALL have port: abort  input  1  cancel the current packet.
REQ-007 SHALL have port: busy  output  1  high from the cycle after an accepted start until done or abort.
REQ-008 SHALL have port: done  output  1  one-cycle pulse, packet fully transferred.
REQ-009 SHALL have port: ram_read_addr  output  ADDRWIDTH  response RAM byte address.
REQ-010 SHALL have port: ram_read_en  output  1  read strobe; data is valid exactly 1 cycle later.
REQ-011 SHALL have port: ram_read_data  input  8  RAM read data.
REQ-012 SHALL have port: dap_out_tvalid  output  1  stream byte valid.
REQ-013 SHALL have port: dap_out_tready  input  1  downstream ready.
REQ-014 SHALL have port: dap_out_tdata  output  8  stream byte.
REQ-015 SHALL have port: dap_out_tlast  output  1  marks the last byte of the packet.

Function
REQ-016 SHALL implement states IDLE, SEND and FLUSH: IDLE->SEND on start with packet_len!=0; SEND->FLUSH after the last read is issued; FLUSH->IDLE on the handshake of the tlast byte.
REQ-017 SHALL, on start with packet_len==0, emit no bytes and pulse done 1 cycle after start, with busy staying low.
REQ-018 SHALL ignore start while busy is high.
REQ-019 SHALL issue reads at addresses 0..packet_len-1 in order, one per cycle at most, incrementing a read counter by 1 per read.
REQ-020 SHALL hold read data in a 2-entry output buffer (output register plus skid register), and issue a read only when buffer occupancy plus in-flight reads is less than 2.
REQ-021 SHALL hold tdata and tlast stable while tvalid is high and tready is low (AXI-stream rules); tvalid SHALL NOT depend combinationally on tready.
REQ-022 SHALL assert dap_out_tvalid for the first byte 2 cycles after the start cycle (read in cycle +1, data in cycle +2).
REQ-023 SHALL sustain 1 byte per cycle while tready is held high, with no bubbles between bytes.
REQ-024 SHALL count bytes with a separate send counter and assert tlast only on byte index packet_len-1.
REQ-025 SHALL pulse done in the cycle after the tlast handshake and drop busy in that same cycle.
REQ-026 SHALL, when start and abort are both high in IDLE, give priority to abort, so start is ignored.
REQ-027 SHALL, on abort while busy, in the next cycle clear tvalid, clear the buffer, discard any in-flight read data, return to IDLE and not pulse done.
REQ-028 SHALL handle packet_len = 2^ADDRWIDTH-1 without counter wrap; the final address is 2^ADDRWIDTH-2.

Reset
REQ-029 SHALL, while resetn is low, force state IDLE with busy=0, done=0, ram_read_en=0, ram_read_addr=0, dap_out_tvalid=0, dap_out_tdata=0 and dap_out_tlast=0, with buffer and counters cleared.
REQ-030 SHALL, on reset mid-packet, drop the packet silently, and after resetn rises the next start SHALL send from address 0.

Verification
REQ-031 SHALL cover: len=4, RAM[0..3]=11,22,33,44, tready=1 -> bytes 11,22,33,44 on consecutive cycles from start+2, tlast with 44, done at start+6.
REQ-032 SHALL cover: len=5, tready toggling 1,0 each cycle -> 5 bytes in order, no drop or duplicate, tdata stable while stalled, tlast only on the 5th byte.
REQ-033 SHALL cover: len=0 -> no tvalid, done pulse at start+1, busy never high.
REQ-034 SHALL cover: len=8, tready=0 for 10 cycles then 1 -> at most 2 reads issued during the stall, then all 8 bytes delivered correctly.
REQ-035 SHALL cover: len=16 with abort after the 3rd handshake -> tvalid low the next cycle, no done, and a following start with len=2 sends RAM[0],RAM[1].
REQ-036 SHALL cover: len=1023 with random tready -> addresses 0..1022 read once each, 1023 bytes, tlast on the last byte, exactly one done pulse.
